mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_rr.sv | 29 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the mem_arbiter memory front-end.
// FSM state encodings are kept as plain constants to match the legacy netlist.
package mem_arb_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_MEM_NUMBER = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 7;
  localparam int unsigned DEF_NUM_REQ    = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_RD_WAIT = 2'd2;
  localparam state_t ST_RSP     = 2'd3;

  // Index of the set bit in a one-hot vector of up to eight requesters.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Rotating-priority winner select: search begins at ptr_i+1 and wraps.
// A fixed pointer of NUM_REQ-1 gives plain lowest-index-first priority.
module mem_arb_rr #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic found;

  // Offset k walks the search order; position i matches when (ptr+k) mod NUM_REQ == i.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] &&
            ((32'(ptr_i) + k == i) || (32'(ptr_i) + k == i + NUM_REQ))) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-requester single-port memory arbiter: IDLE -> ISSUE -> (RD_WAIT) -> RSP.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned MEM_NUMBER = DEF_MEM_NUMBER,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH*MEM_NUMBER-1:0] req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [WIDTH*MEM_NUMBER-1:0]      rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [WIDTH*MEM_NUMBER-1:0]      mem_wdata,
  output logic                             mem_wr_en,
  output logic                             mem_rd_en,
  input  logic [WIDTH*MEM_NUMBER-1:0]      mem_rdata,
  output logic                             busy
);

  localparam int unsigned DW = WIDTH * MEM_NUMBER;
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    win_q, win_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]         rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         ptr;
  logic                  accept;

  mem_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr),
    .gnt_o (gnt)
  );

  assign gnt_idx = PW'(onehot2idx(8'(gnt)));
  assign accept  = (state_q == ST_IDLE) && rst && (|req_valid);

  // Grant is only visible while idle and out of reset, so at most one per transaction.
  assign req_ready = ((state_q == ST_IDLE) && rst) ? gnt : '0;

`ifdef MEM_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  assign ptr_d = accept ? gnt_idx : ptr_q;
  assign ptr   = ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PW'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ptr = PW'(NUM_REQ - 1);
`endif

  // The accepted command is registered straight into the memory outputs,
  // so the strobes are high exactly during the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    write_d     = write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          win_d       = gnt;
          write_d     = req_write[gnt_idx];
          mem_addr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = req_wdata[gnt_idx*DW +: DW];
          mem_wr_en_d = req_write[gnt_idx];
          mem_rd_en_d = ~req_write[gnt_idx];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (write_q) begin
          rsp_valid_d = win_q;
          state_d     = ST_RSP;
        end else begin
          state_d     = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        rsp_rdata_d = mem_rdata;
        rsp_valid_d = win_q;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      write_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      write_q     <= write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
